fir_serial_ctrl: RTL and testbench



---
 rtl/fir_serial_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fir_serial_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fir_serial_ctrl.sv
// fir_serial_ctrl: time-multiplexed symmetric FIR engine.
// One pre-adder, one multiplier and one accumulator are shared across all
// NPAIR coefficient pairs. Each accepted sample is written into a circular
// buffer, and the sequencer then walks the pairs and emits one output.
// Optional macro FIR_COE_WR_EN adds runtime-writable coefficient registers.
// Without it the coefficients are the constant defaults.
module fir_serial_ctrl #(
    parameter  int DW    = 12,
    parameter  int CW    = 12,
    parameter  int TAPS  = 16,
    parameter  int OW    = 29,
    localparam int NPAIR = TAPS / 2,
    localparam int KW    = (NPAIR > 1) ? $clog2(NPAIR) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] xin,
    output logic          ready,
`ifdef FIR_COE_WR_EN
    input  logic          coe_we,
    input  logic [KW-1:0] coe_addr,
    input  logic [CW-1:0] coe_wdata,
`endif
    output logic          valid,
    output logic [OW-1:0] yout,
    output logic          ovf
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW = DW + 1 + CW;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_FLUSH, S_OUT} state_t;

    state_t        r_state, w_next;
    logic [DW-1:0] r_buf [TAPS];
    logic [AW-1:0] r_wp;
    logic [KW-1:0] r_k;
    logic [PW-1:0] r_prod;
    logic [OW-1:0] r_acc, r_yout;
    logic          r_valid, r_ovf;

    logic [DW-1:0] w_xa, w_xb;
    logic [DW:0]   w_pair;
    logic [CW-1:0] w_coe;
    logic [PW-1:0] w_prod;

    // Default coefficient table; only defined for the 16-tap filter.
    function automatic logic [CW-1:0] f_def(input logic [31:0] i);
        logic [31:0] v;
        v = 32'd0;
        if (TAPS == 16) begin
            case (i)
                32'd0:   v = 32'd11;
                32'd1:   v = 32'd31;
                32'd2:   v = 32'd63;
                32'd3:   v = 32'd104;
                32'd4:   v = 32'd152;
                32'd5:   v = 32'd198;
                32'd6:   v = 32'd235;
                32'd7:   v = 32'd255;
                default: v = 32'd0;
            endcase
        end
        return CW'(v);
    endfunction

    // Buffer slot holding x[j]. The write pointer already points past the newest sample.
    function automatic logic [AW-1:0] f_idx(input logic [AW-1:0] p, input logic [31:0] j);
        logic [31:0] t;
        t = 32'(p) + 32'(TAPS) - 32'd1 - j;
        if (t >= 32'(TAPS)) t = t - 32'(TAPS);
        return t[AW-1:0];
    endfunction

`ifdef FIR_COE_WR_EN
    logic [CW-1:0] r_coe [NPAIR];

    // Coefficient registers: writable only while idle and no sample is arriving.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPAIR; i++) r_coe[i] <= f_def(32'(i));
        end else if (coe_we && r_state == S_IDLE && !en) begin
            r_coe[coe_addr] <= coe_wdata;
        end
    end

    assign w_coe = r_coe[r_k];
`else
    assign w_coe = f_def(32'(r_k));
`endif

    // Shared pre-adder and multiplier for pair k.
    always_comb begin
        w_xa   = r_buf[f_idx(r_wp, 32'(r_k))];
        w_xb   = r_buf[f_idx(r_wp, 32'(TAPS - 1) - 32'(r_k))];
        w_pair = {1'b0, w_xa} + {1'b0, w_xb};
        w_prod = PW'(w_coe) * PW'(w_pair);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and ready. OUT also accepts a sample, which gives a period of NPAIR+2 under back-pressure.
    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (en) w_next = S_MAC;
            end
            S_MAC: begin
                if (r_k == KW'(NPAIR - 1)) w_next = S_FLUSH;
            end
            S_FLUSH: w_next = S_OUT;
            S_OUT: begin
                ready  = 1'b1;
                w_next = en ? S_MAC : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Sample buffer, MAC datapath, output register and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) r_buf[i] <= '0;
            r_wp    <= '0;
            r_k     <= '0;
            r_prod  <= '0;
            r_acc   <= '0;
            r_yout  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (en && !ready) r_ovf <= 1'b1;
            case (r_state)
                S_IDLE, S_OUT: begin
                    if (r_state == S_OUT) begin
                        r_yout  <= r_acc;
                        r_valid <= 1'b1;
                    end
                    if (en) begin
                        r_buf[r_wp] <= xin;
                        r_wp        <= (r_wp == AW'(TAPS - 1)) ? '0 : r_wp + 1'b1;
                        r_acc       <= '0;
                        r_k         <= '0;
                    end
                end
                S_MAC: begin
                    r_prod <= w_prod;
                    r_k    <= r_k + 1'b1;
                    if (r_k != '0) r_acc <= r_acc + OW'(r_prod);
                end
                S_FLUSH: r_acc <= r_acc + OW'(r_prod);
                default: ;
            endcase
        end
    end

    assign valid = r_valid;
    assign yout  = r_yout;
    assign ovf   = r_ovf;
endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Directed self-checking bench for fir_serial_ctrl (default 16-tap build).
module tb_fir_serial_ctrl;
    localparam int DW = 12, CW = 12, TAPS = 16, OW = 29, KW = 3;

    logic          clk = 1'b0;
    logic          rst, en, ready, valid, ovf;
    logic [DW-1:0] xin;
    logic [OW-1:0] yout;
`ifdef FIR_COE_WR_EN
    logic          coe_we;
    logic [KW-1:0] coe_addr;
    logic [CW-1:0] coe_wdata;
`endif

    int checks   = 0;
    int failures = 0;
    int coe_def [8] = '{11, 31, 63, 104, 152, 198, 235, 255};

    fir_serial_ctrl #(.DW(DW), .CW(CW), .TAPS(TAPS), .OW(OW)) dut (
        .clk(clk), .rst(rst), .en(en), .xin(xin), .ready(ready),
`ifdef FIR_COE_WR_EN
        .coe_we(coe_we), .coe_addr(coe_addr), .coe_wdata(coe_wdata),
`endif
        .valid(valid), .yout(yout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; xin = '0;
`ifdef FIR_COE_WR_EN
        coe_we = 1'b0; coe_addr = '0; coe_wdata = '0;
`endif
        tick; tick;
        rst = 1'b0;
    endtask

    // Accept one sample and return its output plus cycles from accept edge to valid (-1 on timeout).
    task automatic send(input logic [DW-1:0] x, output logic [OW-1:0] y, output int lat);
        int n;
        lat = -1; y = 'x; n = 0;
        while (!ready && n < 50) begin tick; n++; end
        en = 1'b1; xin = x;
        tick;
        en = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick;
            if (valid) begin lat = c; y = yout; break; end
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (yout !== '0) begin failures++; $display("FAIL reset_yout got=%0d exp=0", yout); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_impulse;
        logic [OW-1:0] y;
        int lat, e;
        do_reset;
        for (int n = 0; n < 17; n++) begin
            send((n == 0) ? 12'd1 : 12'd0, y, lat);
            e = (n < 8) ? coe_def[n] : (n < 16) ? coe_def[15-n] : 0;
            checks++; if (y !== OW'(e)) begin failures++; $display("FAIL impulse[%0d] got=%0d exp=%0d", n, y, e); end
            checks++; if (lat !== 10) begin failures++; $display("FAIL impulse_lat[%0d] got=%0d exp=10", n, lat); end
        end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL impulse_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_step;
        logic [OW-1:0] y;
        int lat;
        do_reset;
        for (int n = 0; n < 17; n++) begin
            send(12'd100, y, lat);
            if (n == 0) begin
                checks++; if (y !== OW'(1100)) begin failures++; $display("FAIL step_first got=%0d exp=1100", y); end
            end
            if (n >= 15) begin
                checks++; if (y !== OW'(209800)) begin failures++; $display("FAIL step[%0d] got=%0d exp=209800", n, y); end
            end
        end
    endtask

    task automatic test_full_scale;
        logic [OW-1:0] y;
        int lat;
        do_reset;
        for (int n = 0; n < 16; n++) begin
            send(12'd4095, y, lat);
            if (n == 0) begin
                checks++; if (y !== OW'(45045)) begin failures++; $display("FAIL full_first got=%0d exp=45045", y); end
            end
        end
        checks++; if (y !== OW'(8591310)) begin failures++; $display("FAIL full_scale got=%0d exp=8591310", y); end
    endtask

    // en held high: period 10, dropped samples only raise ovf and leave the buffer alone.
    task automatic test_back_to_back;
        int ey [4] = '{11, 42, 105, 209};
        do_reset;
        en = 1'b1; xin = 12'd1;
        tick;
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL bp_ovf0 got=%b exp=0", ovf); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL bp_ready0 got=%b exp=0", ready); end
        for (int i = 1; i <= 40; i++) begin
            tick;
            checks++; if (valid !== (i % 10 == 0)) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=%b", i, valid, (i % 10 == 0)); end
            checks++; if (ready !== (i % 10 == 9)) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=%b", i, ready, (i % 10 == 9)); end
            checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL bp_ovf[%0d] got=%b exp=1", i, ovf); end
            if (i % 10 == 0) begin
                checks++; if (yout !== OW'(ey[i/10-1])) begin failures++; $display("FAIL bp_yout[%0d] got=%0d exp=%0d", i, yout, ey[i/10-1]); end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reset_midop;
        logic [OW-1:0] y;
        int lat;
        bit seen;
        do_reset;
        en = 1'b1; xin = 12'd50;
        tick;
        en = 1'b0;
        tick; tick; tick;
        rst = 1'b1;
        tick;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midop_valid got=%b exp=0", valid); end
        checks++; if (yout !== '0) begin failures++; $display("FAIL midop_yout got=%0d exp=0", yout); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL midop_ready got=%b exp=1", ready); end
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin tick; if (valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midop_novalid got=%b exp=0", seen); end
        send(12'd1, y, lat);
        checks++; if (y !== OW'(11)) begin failures++; $display("FAIL midop_next got=%0d exp=11", y); end
        checks++; if (lat !== 10) begin failures++; $display("FAIL midop_lat got=%0d exp=10", lat); end
    endtask

`ifdef FIR_COE_WR_EN
    task automatic test_coe_write;
        logic [OW-1:0] y;
        int lat, e, c;
        do_reset;
        coe_we = 1'b1; coe_addr = 3'd7; coe_wdata = '0;
        tick;
        coe_we = 1'b0;
        // First impulse sample with an attempted write of coe[0] during MAC.
        en = 1'b1; xin = 12'd1;
        tick;
        en = 1'b0;
        tick;
        coe_we = 1'b1; coe_addr = 3'd0; coe_wdata = '0;
        tick;
        coe_we = 1'b0;
        y = 'x; c = 2;
        while (!valid && c < 30) begin tick; c++; end
        checks++; if (valid !== 1'b1 || yout !== OW'(11)) begin failures++; $display("FAIL coe_mac_write got=%0d exp=11", yout); end
        for (int n = 1; n < 16; n++) begin
            send(12'd0, y, lat);
            e = (n == 7 || n == 8) ? 0 : (n < 8) ? coe_def[n] : coe_def[15-n];
            checks++; if (y !== OW'(e)) begin failures++; $display("FAIL coe_impulse[%0d] got=%0d exp=%0d", n, y, e); end
        end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL coe_ovf got=%b exp=0", ovf); end
        do_reset;
    endtask
`endif

    initial begin
        test_reset;
        test_impulse;
        test_step;
        test_full_scale;
        test_back_to_back;
        test_reset_midop;
`ifdef FIR_COE_WR_EN
        test_coe_write;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
